// File: rtl/alu_pkg.sv
// Purpose: shared ALU opcode encodings and arbiter state type for the ALU sharing block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd1;
    localparam logic [5:0] ALU_AND  = 6'd2;
    localparam logic [5:0] ALU_OR   = 6'd3;
    localparam logic [5:0] ALU_XOR  = 6'd4;
    localparam logic [5:0] ALU_SLL  = 6'd5;
    localparam logic [5:0] ALU_SRL  = 6'd6;
    localparam logic [5:0] ALU_SRA  = 6'd7;
    localparam logic [5:0] ALU_SLT  = 6'd8;
    localparam logic [5:0] ALU_SLTU = 6'd9;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Purpose: round-robin winner search, first valid requester at or after rr_ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic                gnt_valid,
    output logic [ID_WIDTH-1:0] gnt_id
);

    // Walk NUM_REQ slots starting at rr_ptr; the first valid slot wins.
    always_comb begin : search
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_valid && req_valid[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Purpose: time-share one combinational ALU among NUM_REQ requesters, round-robin.
// Latency: accept at cycle T, rsp_valid at T+2; one op per 3 cycles at best.
// Backpressure: result held until rsp_ready; no new request accepted until it drains.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 6,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*CTRL_WIDTH-1:0]  req_ctrl,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
    output logic [CTRL_WIDTH-1:0]          alu_ctrl_out,
    output logic [DATA_WIDTH-1:0]          alu_a_out,
    output logic [DATA_WIDTH-1:0]          alu_b_out,
    input  logic [DATA_WIDTH-1:0]          alu_result_in,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           busy
);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  gnt_valid;
    logic [ID_WIDTH-1:0]   gnt_id;

    logic [CTRL_WIDTH-1:0] ctrl_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] a_arr    [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr    [NUM_REQ];

    // Unpack the flat per-requester buses into indexable arrays.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign ctrl_arr[g] = req_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH];
        assign a_arr[g]    = req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[g]    = req_b[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the one-hot accept pulse; only IDLE may accept.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    req_ready[gnt_id] = 1'b1;
                    state_nxt         = ARB_ISSUE;
                end
            end
            ARB_ISSUE: state_nxt = ARB_RESP;
            ARB_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Datapath: latch winner operands, capture ALU result, advance the pointer on drain.
    // ALU inputs only change on acceptance so the ALU sees stable operands otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_id     <= '0;
            rr_ptr       <= '0;
            alu_ctrl_out <= '0;
            alu_a_out    <= '0;
            alu_b_out    <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        grant_id     <= gnt_id;
                        alu_ctrl_out <= ctrl_arr[gnt_id];
                        alu_a_out    <= a_arr[gnt_id];
                        alu_b_out    <= b_arr[gnt_id];
                    end
                end
                ARB_ISSUE: begin
                    rsp_data  <= alu_result_in;
                    rsp_id    <= grant_id;
                    rsp_valid <= 1'b1;
                end
                ARB_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                          : grant_id + ID_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose: self-checking bench for alu_share_arbiter with a behavioural ALU and reference model.
// Latency: n/a.
// Backpressure: rsp_ready driven both directed and randomly.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 6;
    localparam int IW = 2;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*CW-1:0] req_ctrl;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [CW-1:0]   alu_ctrl_out;
    logic [DW-1:0]   alu_a_out;
    logic [DW-1:0]   alu_b_out;
    logic [DW-1:0]   alu_result_in;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    logic [CW-1:0]   op_ctrl [N];
    logic [DW-1:0]   op_a    [N];
    logic [DW-1:0]   op_b    [N];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state, expressed in cycle timestamps rather than FSM states.
    bit             in_flight;
    int             acc_cyc;
    int             exp_id;
    int             ptr;
    logic [DW-1:0]  exp_data;
    logic [CW-1:0]  last_ctrl;
    logic [DW-1:0]  last_a;
    logic [DW-1:0]  last_b;
    bit             acc_seen [N];

    // Observed DUT grants and completed responses.
    int             g_id  [$];
    int             g_cyc [$];
    int             r_id  [$];
    int             r_cyc [$];
    logic [DW-1:0]  r_data[$];

    alu_share_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .ID_WIDTH   (IW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_ctrl      (req_ctrl),
        .req_a         (req_a),
        .req_b         (req_b),
        .alu_ctrl_out  (alu_ctrl_out),
        .alu_a_out     (alu_a_out),
        .alu_b_out     (alu_b_out),
        .alu_result_in (alu_result_in),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .busy          (busy)
    );

    function automatic logic [DW-1:0] alu_fn(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (c)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return DW'($signed(a) >>> b[4:0]);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return '0;
        endcase
    endfunction

    assign alu_result_in = alu_fn(alu_ctrl_out, alu_a_out, alu_b_out);

    always_comb begin
        req_ctrl = '0;
        req_a    = '0;
        req_b    = '0;
        for (int i = 0; i < N; i++) begin
            req_ctrl[i*CW +: CW] = op_ctrl[i];
            req_a[i*DW +: DW]    = op_a[i];
            req_b[i*DW +: DW]    = op_b[i];
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Per-cycle reference model and monitor, sampled on the falling edge.
    always @(negedge clock) begin : model
        logic [N-1:0] exp_rdy;
        int           win;
        int           idx;
        bit           rsp_exp;
        exp_rdy = '0;
        win     = -1;
        rsp_exp = 1'b0;
        if (!reset) begin
            in_flight = 1'b0;
            ptr       = 0;
            last_ctrl = '0;
            last_a    = '0;
            last_b    = '0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_alu_a", alu_a_out, 0);
        end else begin
            if (!in_flight) begin
                for (int k = 0; k < N; k++) begin
                    idx = (ptr + k) % N;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            rsp_exp = in_flight && (cyc >= acc_cyc + 2);
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, in_flight);
            chk("rsp_valid", rsp_valid, rsp_exp);
            if (rsp_exp) begin
                chk("rsp_id", rsp_id, exp_id);
                chk("rsp_data", rsp_data, exp_data);
            end
            chk("alu_ctrl_hold", alu_ctrl_out, last_ctrl);
            chk("alu_a_hold", alu_a_out, last_a);
            chk("alu_b_hold", alu_b_out, last_b);

            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    g_id.push_back(i);
                    g_cyc.push_back(cyc);
                    if (req_valid[i]) acc_seen[i] = 1'b1;
                end
            end
            if (rsp_valid && rsp_ready) begin
                r_id.push_back(int'(rsp_id));
                r_cyc.push_back(cyc);
                r_data.push_back(rsp_data);
            end

            if (rsp_exp && rsp_ready) begin
                in_flight = 1'b0;
                ptr       = (exp_id + 1) % N;
            end else if (win >= 0) begin
                in_flight = 1'b1;
                acc_cyc   = cyc;
                exp_id    = win;
                exp_data  = alu_fn(op_ctrl[win], op_a[win], op_b[win]);
                last_ctrl = op_ctrl[win];
                last_a    = op_a[win];
                last_b    = op_b[win];
            end
        end
    end

    // One clock step; requesters release their request once it was accepted.
    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_seen[i]) begin
                req_valid[i] = 1'b0;
                acc_seen[i]  = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int i, input logic [CW-1:0] c, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        op_ctrl[i]   = c;
        op_a[i]      = a;
        op_b[i]      = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic clear_logs();
        g_id.delete();
        g_cyc.delete();
        r_id.delete();
        r_cyc.delete();
        r_data.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_ctrl[i]  = '0;
            op_a[i]     = '0;
            op_b[i]     = '0;
            acc_seen[i] = 1'b0;
        end
        repeat (3) tick();
        reset = 1'b1;
        clear_logs();
    endtask

    task automatic wait_gnt(input int n);
        for (int k = 0; k < 60 && g_id.size() < n; k++) tick();
        chk("wait_gnt", g_id.size() >= n, 1);
    endtask

    task automatic wait_rsp_valid();
        for (int k = 0; k < 20 && !rsp_valid; k++) tick();
        chk("wait_rsp_valid", rsp_valid, 1);
    endtask

    initial begin
        int cnt;
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;

        // Single request from requester 0.
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, ALU_ADD, 32'h5, 32'h3);
        wait_gnt(1);
        repeat (5) tick();
        chk("t1_gnt_count", g_id.size(), 1);
        chk("t1_rsp_count", r_id.size(), 1);
        if (g_id.size() == 1 && r_id.size() == 1) begin
            chk("t1_gnt_id", g_id[0], 0);
            chk("t1_rsp_id", r_id[0], 0);
            chk("t1_rsp_data", r_data[0], 32'h8);
            chk("t1_latency", r_cyc[0] - g_cyc[0], 2);
        end

        // All four pending from reset; requester 0 re-requests after its first grant.
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, ALU_ADD, 32'h1, 32'h2);
        set_req(1, ALU_SUB, 32'h10, 32'h3);
        set_req(2, ALU_XOR, 32'hFF00FF00, 32'h0F0F0F0F);
        set_req(3, ALU_SRA, 32'hFFFFFFFF, 32'h3);
        wait_gnt(1);
        set_req(0, ALU_OR, 32'h7, 32'h8);
        wait_gnt(5);
        repeat (4) tick();
        chk("t2_gnt_count", g_id.size(), 5);
        if (g_id.size() >= 5 && r_id.size() >= 4) begin
            for (int k = 0; k < 5; k++) chk("t2_gnt_order", g_id[k], k % 4);
            for (int k = 0; k < 4; k++) chk("t2_gnt_spacing", g_cyc[k+1] - g_cyc[k], 3);
            for (int k = 0; k < 4; k++) chk("t2_rsp_order", r_id[k], k);
            chk("t2_sra", r_data[3], 32'hFFFFFFFF);
        end else begin
            chk("t2_rsp_count", r_id.size() >= 4, 1);
        end

        // Backpressure: result held while consumer stalls, no accepts meanwhile.
        do_reset();
        rsp_ready = 1'b0;
        set_req(2, ALU_AND, 32'h0000F0F0, 32'h0000FF00);
        wait_gnt(1);
        wait_rsp_valid();
        set_req(1, ALU_ADD, 32'h1, 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_hold_valid", rsp_valid, 1);
            chk("t3_hold_data", rsp_data, 32'h0000F000);
            chk("t3_hold_id", rsp_id, 2);
            chk("t3_no_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("t3_idle_busy", busy, 0);
        chk("t3_next_grant", req_ready, 4'b0010);
        tick();
        chk("t3_busy_again", busy, 1);

        // Wrap: after requester 3, pointer returns to 0 before 2.
        do_reset();
        rsp_ready = 1'b1;
        set_req(3, ALU_ADD, 32'h3, 32'h3);
        wait_gnt(1);
        set_req(0, ALU_ADD, 32'h0, 32'h1);
        set_req(2, ALU_ADD, 32'h2, 32'h1);
        wait_gnt(3);
        if (g_id.size() >= 3) begin
            chk("t4_first", g_id[0], 3);
            chk("t4_wrap", g_id[1], 0);
            chk("t4_then2", g_id[2], 2);
        end

        // Reset during a stalled response clears the pointer and drops the result.
        do_reset();
        rsp_ready = 1'b1;
        set_req(2, ALU_ADD, 32'h1, 32'h1);
        wait_gnt(1);
        repeat (4) tick();
        rsp_ready = 1'b0;
        set_req(0, ALU_SUB, 32'h10, 32'h20);
        wait_gnt(2);
        wait_rsp_valid();
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_rsp_valid", rsp_valid, 0);
        chk("t5_async_busy", busy, 0);
        req_valid = '0;
        repeat (2) tick();
        reset = 1'b1;
        clear_logs();
        rsp_ready = 1'b1;
        set_req(1, ALU_ADD, 32'h4, 32'h4);
        set_req(3, ALU_ADD, 32'h6, 32'h6);
        wait_gnt(1);
        repeat (3) tick();
        if (g_id.size() >= 1 && r_id.size() >= 1) begin
            chk("t5_first_grant", g_id[0], 1);
            chk("t5_first_rsp", r_id[0], 1);
            chk("t5_first_data", r_data[0], 32'h8);
        end else begin
            chk("t5_rsp_seen", r_id.size() >= 1, 1);
        end
        repeat (6) tick();

        // Requester 1 valid only while busy, then withdrawn.
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, ALU_ADD, 32'h9, 32'h1);
        wait_gnt(1);
        set_req(1, ALU_SUB, 32'h9, 32'h1);
        tick();
        req_valid[1] = 1'b0;
        repeat (8) tick();
        cnt = 0;
        foreach (g_id[k]) if (g_id[k] == 1) cnt++;
        foreach (r_id[k]) if (r_id[k] == 1) cnt++;
        chk("t6_no_req1", cnt, 0);
        chk("t6_rsp_count", r_id.size(), 1);

        // Randomised traffic with occasional withdrawals and consumer stalls.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, CW'($urandom_range(0, 9)), $urandom, $urandom);
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        chk("rand_progress", r_id.size() > 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
